// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between the fetch PC and instruction memory.
// Combinational hit path; misses stall fetch while the whole line is refilled over req/ack.
module instr_cache #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SETS       = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] addr,
    input  logic             inv,
    output logic [WIDTH-1:0] instr,
    output logic             hit,
    output logic             stall,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int unsigned OB = $clog2(LINE_WORDS);
    localparam int unsigned IB = $clog2(SETS);
    localparam int unsigned TB = WIDTH - OB - IB - 2;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t           r_state;
    logic [SETS-1:0]  r_valid;
    logic [TB-1:0]    r_tags [SETS];
    logic [WIDTH-1:0] r_data [SETS][LINE_WORDS];
    logic [IB-1:0]    r_idx;
    logic [TB-1:0]    r_tag;
    logic [OB-1:0]    r_cnt;
    logic             r_inv_pend;

    logic [IB-1:0]    w_idx;
    logic [OB-1:0]    w_off;
    logic [TB-1:0]    w_tag;
    logic             w_hit;
    logic             w_last;
    logic             w_wr;
    logic             w_unused_lsb;

    assign w_off        = addr[OB+1:2];
    assign w_idx        = addr[OB+IB+1:OB+2];
    assign w_tag        = addr[WIDTH-1:OB+IB+2];
    assign w_unused_lsb = ^addr[1:0];

    assign w_hit  = (r_state == S_IDLE) && r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_last = (r_cnt == OB'(LINE_WORDS - 1));
    assign w_wr   = (r_state == S_FILL) && mem_ack && !rst;

    assign hit   = w_hit;
    assign stall = !w_hit;
    assign instr = w_hit ? r_data[w_idx][w_off] : NOP;

    // Line data array: never reset, only written by refill beats.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_data[r_idx][r_cnt] <= mem_rdata;
        end
    end

    // Lookup/refill controller; refill runs only on values latched at the miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_cnt      <= '0;
            r_inv_pend <= 1'b0;
            r_idx      <= '0;
            r_tag      <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inv) begin
                        r_valid <= '0;
                    end else if (!w_hit) begin
                        r_idx    <= w_idx;
                        r_tag    <= w_tag;
                        r_cnt    <= '0;
                        mem_req  <= 1'b1;
                        mem_addr <= {addr[WIDTH-1:OB+2], {(OB+2){1'b0}}};
                        r_state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (inv) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_ack) begin
                        r_cnt <= r_cnt + OB'(1);
                        if (w_last) begin
                            mem_req    <= 1'b0;
                            r_state    <= S_IDLE;
                            r_inv_pend <= 1'b0;
                            // An invalidate seen at any point of the fill wins over the new line.
                            if (r_inv_pend || inv) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[r_idx] <= 1'b1;
                                r_tags[r_idx]  <= r_tag;
                            end
                        end else begin
                            mem_addr <= mem_addr + WIDTH'(4);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_cache.sv
// Scoreboard bench for instr_cache: directed test-plan scenarios followed by random traffic,
// checked against an array-based model of the cache contents and refill progress.
module tb_instr_cache;

    localparam int unsigned SETS = 16;
    localparam int unsigned LW   = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        inv;
    logic        hit;
    logic        stall;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        hit;
        logic [31:0] instr;
        logic        req;
        logic        chk_addr;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit          m_known = 0;
    bit          m_valid [SETS];
    int unsigned m_tag   [SETS];
    logic [31:0] m_line  [SETS][LW];
    bit          m_filling, m_pend, m_clean;
    int unsigned m_base, m_done, m_fidx, m_ftag;

    logic obs_stall;

    instr_cache #(.WIDTH(32), .SETS(SETS), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst), .addr(addr), .inv(inv),
        .instr(instr), .hit(hit), .stall(stall),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return ((a >> 2) + 32'd1) * 32'h11;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a >> 4) % SETS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> 8;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return !m_filling && m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic void clear_all();
        for (int i = 0; i < SETS; i++) m_valid[i] = 0;
    endfunction

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_expect(input logic [31:0] a, output exp_t e);
        e.hit      = model_hit(a);
        e.instr    = e.hit ? m_line[idx_of(a)][(a >> 2) % LW] : NOP;
        e.req      = m_filling;
        e.chk_addr = m_filling || m_clean;
        e.maddr    = m_filling ? m_base + 4 * m_done : 32'h0;
    endfunction

    function automatic void model_step(input logic [31:0] a, input logic iv, input logic ak, input logic rs);
        if (rs) begin
            clear_all();
            m_filling = 0;
            m_pend    = 0;
            m_clean   = 1;
            m_known   = 1;
            return;
        end
        if (!m_known) return;
        if (!m_filling) begin
            if (iv) clear_all();
            else if (!model_hit(a)) begin
                m_filling = 1;
                m_base    = a & ~32'(LW * 4 - 1);
                m_done    = 0;
                m_fidx    = idx_of(a);
                m_ftag    = tag_of(a);
                m_clean   = 0;
            end
        end else begin
            if (iv) m_pend = 1;
            if (ak) begin
                m_line[m_fidx][m_done] = mem_word(m_base + 4 * m_done);
                m_done++;
                if (m_done == LW) begin
                    m_filling = 0;
                    if (m_pend) clear_all();
                    else begin
                        m_valid[m_fidx] = 1;
                        m_tag[m_fidx]   = m_ftag;
                    end
                    m_pend = 0;
                end
            end
        end
    endfunction

    // One fetch cycle: drive inputs, queue the expected response, advance the model at the edge.
    task automatic cycle(input logic [31:0] a, input logic iv, input logic ak, input logic rs);
        exp_t e;
        addr    = a;
        inv     = iv;
        mem_ack = ak;
        rst     = rs;
        #1;
        obs_stall = stall;
        if (m_known) begin
            model_expect(a, e);
            sb.push_back(e);
        end
        @(posedge clk);
        model_step(a, iv, ak, rs);
        #1;
    endtask

    // Hold an address until it hits, counting stall cycles; mode 1 acks every third fill cycle.
    task automatic run_fill(input logic [31:0] a, input int mode, input int inv_k,
                            input int exp_stalls, input string nm);
        int  stalls = 0;
        bit  done   = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            logic ak;
            ak = (mode == 0) ? 1'b1 : ((k > 0) && (k % 3 == 0));
            cycle(a, (k == inv_k), ak, 1'b0);
            if (obs_stall) stalls++;
            else done = 1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=no_hit expected=hit_within_60", nm);
        end
        check(nm, 32'(stalls), 32'(exp_stalls));
    endtask

    // Monitor: compare the DUT against the queued expectation mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("hit", 32'(hit), 32'(e.hit));
                check("stall", 32'(stall), 32'(!e.hit));
                check("instr", instr, e.instr);
                check("mem_req", 32'(mem_req), 32'(e.req));
                if (e.chk_addr) check("mem_addr", mem_addr, e.maddr);
            end
        end
    end

    initial begin
        addr = '0; inv = 0; mem_ack = 0; rst = 1;
        cycle(32'h0, 1'b0, 1'b0, 1'b1);
        cycle(32'h0, 1'b0, 1'b0, 1'b1);

        run_fill(32'h0, 0, -1, 5, "cold_start_stalls");
        cycle(32'h4, 1'b0, 1'b0, 1'b0);
        cycle(32'h8, 1'b0, 1'b0, 1'b0);
        cycle(32'hC, 1'b0, 1'b0, 1'b0);
        check("reuse_word3", instr, 32'h44);

        run_fill(32'h100, 0, -1, 5, "conflict_fill_stalls");
        run_fill(32'h0, 0, -1, 5, "conflict_refetch_stalls");

        run_fill(32'h200, 1, -1, 13, "wait_state_stalls");

        cycle(32'h200, 1'b1, 1'b0, 1'b0);
        run_fill(32'h200, 0, -1, 5, "inv_idle_refill_stalls");

        run_fill(32'h300, 0, 2, 10, "inv_during_fill_stalls");

        cycle(32'h400, 1'b0, 1'b1, 1'b0);
        cycle(32'h400, 1'b0, 1'b1, 1'b0);
        cycle(32'h400, 1'b0, 1'b1, 1'b0);
        cycle(32'h400, 1'b0, 1'b1, 1'b1);
        run_fill(32'h0, 0, -1, 5, "refill_after_rst_stalls");

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 32'h7FF));
            cycle(a, ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 199) == 0));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the fetch-stage PC and the backing instruction memory. It returns the 32-bit instruction for the PC combinationally on a hit. On a miss it raises `stall` toward the program counter and the FEC/DEC register, refills the whole line word by word over a req/ack handshake, then resumes. It replaces the direct fetch-stage connection to `instr_mem`; `instr_mem` becomes the backing store behind the handshake.

## Interface
Parameters:
- `WIDTH`, 32, data and address width.
- `SETS`, 16, number of lines; power of two, ≥2.
- `LINE_WORDS`, 4, words per line; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `addr`  in  WIDTH  fetch address (PCF); `addr[1:0]` ignored.
- `inv`  in  1  invalidate all lines (fence.i).
- `instr`  out  WIDTH  instruction word; 0x00000013 (NOP) whenever `hit`=0.
- `hit`  out  1  `instr` is valid for `addr` this cycle.
- `stall`  out  1  = !`hit`; freezes PC and FEC/DEC register.
- `mem_req`  out  1  refill read request.
- `mem_addr`  out  WIDTH  word-aligned refill address.
- `mem_ack`  in  1  `mem_rdata` valid; sampled only while `mem_req`=1.
- `mem_rdata`  in  WIDTH  refill data word.

## Operation
- Address split (OB = log2(LINE_WORDS), IB = log2(SETS)):
  - word offset `addr[OB+1:2]`
  - index `addr[OB+IB+1:OB+2]`
  - tag = remaining upper bits
- Storage per set: valid bit, tag, LINE_WORDS data words. Only valid bits are reset.
- `hit` = state IDLE && valid[index] && tag match. Lookup is combinational. `instr` = data[index][word offset] on a hit, otherwise NOP.
- FSM, two states:
  - IDLE:
    - on miss with `inv`=0: latch line base (`addr` with offset bits and [1:0] cleared) and index/tag, clear word counter, go to FILL.
    - on `inv`=1: clear all valid bits; no fill starts that cycle.
  - FILL:
    - `mem_req`=1, `mem_addr` = base + 4×counter.
    - on `mem_ack`: write `mem_rdata` to data[latched index][counter] and increment counter.
    - on the ack with counter = LINE_WORDS−1: write valid and tag, then go to IDLE.
- Word order is sequential from word 0; no critical-word-first.
- `mem_req` and `mem_addr` stay stable until acked. `mem_req` is never dropped mid-fill except on reset.
- Fill uses only latched values, so `addr` changes during FILL do not affect it. Back in IDLE the current `addr` is looked up again; if it mismatches, a new miss starts.
- `inv` during FILL is recorded as pending. At fill end, all valid bits are cleared and the just-filled line is not marked valid; the next lookup misses again.
- `inv` coinciding with the final ack behaves the same as `inv` during FILL.
- `mem_ack` in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, all valid=0, counter=0, pending-inv=0
  - `mem_req`=0, `mem_addr`=0
  - `hit`=0, `stall`=1, `instr`=NOP (no valid lines)
- Hit latency: 0 cycles (combinational from `addr`).
- Miss detected in cycle N → `mem_req` high from N+1.
- With single-cycle acks, the line is written at the end of N+LINE_WORDS and `hit`=1 in cycle N+LINE_WORDS+1. The default miss penalty is 5 stall cycles.
- Each wait cycle without `mem_ack` adds one stall cycle.
- Reset mid-fill:
  - `mem_req`=0 from the next cycle.
  - The partial line is discarded and all lines become invalid.
  - The backing memory must tolerate an abandoned request.
- `rst` overrides `inv` and `mem_ack`.

## Test plan
- Cold start: reset, `addr`=0x0, ack every cycle with 0x11,0x22,0x33,0x44 → `mem_addr` 0x0/0x4/0x8/0xC in cycles 1–4, `stall`=1 in cycles 0–4, cycle 5 `hit`=1 `instr`=0x11.
- Line reuse: after cold start, step `addr` 0x4→0x8→0xC → `instr` 0x22/0x33/0x44, `hit`=1, `mem_req` never asserted.
- Conflict: `addr`=0x100 (same index 0, different tag) → refill from 0x100–0x10C; then `addr`=0x0 misses again and refetches from 0x0.
- Wait states: ack only every third cycle → `mem_addr` held constant between acks, `stall`=1 for 1+12 cycles, then hit with the correct data.
- Invalidate:
  - `inv` in IDLE with line 0 valid → next cycle `addr`=0x0 misses.
  - `inv` pulsed during the second fill word → fill completes, then `addr` still misses and triggers a new fill.
- Reset mid-fill: `rst` after 2 of 4 acks → `mem_req`=0 next cycle, `hit`=0; new fill restarts at word 0 (`mem_addr`=0x0).
